// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencing for the five-stage pipeline registers and PC
module pipeline_hazard_ctrl #(
    parameter int COMPLEX_LAT = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic             ex_mem_read_en,
    input  logic [4:0]       ex_write_register,
    input  logic             ex_complex,
    input  logic             ex_branch_taken,
    input  logic             ex_halted,
    input  logic             mem_cache_miss,
    input  logic             mem_cache_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_CACHE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // Detect cycle plus COMPLEX_LAT-2 busy cycles plus one release cycle.
    localparam logic [3:0] CX_LOAD = 4'(COMPLEX_LAT - 2);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;

    always_comb begin
        load_use = ex_mem_read_en && (ex_write_register != 5'd0) &&
                   ((id_uses_src1 && (id_src1 == ex_write_register)) ||
                    (id_uses_src2 && (id_src2 == ex_write_register)));
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (!rst_b) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = S_RUN;
            cnt_d       = 4'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (ex_halted) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        state_d  = S_HALT;
                    end else if (mem_cache_miss) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        state_d  = S_CACHE;
                    end else if (ex_complex) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_d       = CX_LOAD;
                        state_d     = S_BUSY;
                    end else if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_d       = cnt_q - 4'd1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_CACHE: begin
                    if (!mem_cache_ready) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end
            endcase
        end

        stall_d = stall_q;
        if (!pc_en && (state_q != S_HALT) && (state_d != S_HALT) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= S_RUN;
            cnt_q   <= 4'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign halted       = (state_q == S_HALT);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl with directed vectors
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [4:0] id_src1, id_src2, ex_write_register;
    logic       id_uses_src1, id_uses_src2, ex_mem_read_en, ex_complex;
    logic       ex_branch_taken, ex_halted, mem_cache_miss, mem_cache_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, exmem_flush, halted;
    logic [3:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.COMPLEX_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .ex_mem_read_en(ex_mem_read_en), .ex_write_register(ex_write_register),
        .ex_complex(ex_complex), .ex_branch_taken(ex_branch_taken),
        .ex_halted(ex_halted), .mem_cache_miss(mem_cache_miss),
        .mem_cache_ready(mem_cache_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    // Control vector order: pc, ifid, idex, exmem enables, ifid/idex/exmem flushes, halted.
    localparam int C_DEF  = 'b1111_0000;
    localparam int C_ALL0 = 'b0000_0000;
    localparam int C_RST  = 'b0000_1110;
    localparam int C_LU   = 'b0011_0100;
    localparam int C_BR   = 'b1111_1100;
    localparam int C_CX   = 'b0001_0010;
    localparam int C_HALT = 'b0000_0001;

    localparam logic [5:0] F_RD = 6'b100000;
    localparam logic [5:0] F_CX = 6'b010000;
    localparam logic [5:0] F_BR = 6'b001000;
    localparam logic [5:0] F_HT = 6'b000100;
    localparam logic [5:0] F_MS = 6'b000010;
    localparam logic [5:0] F_RY = 6'b000001;

    typedef struct {
        string name;
        int    ctl;
        int    cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step(input string name, input logic rst, input logic [5:0] f,
                        input logic [4:0] wr, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2, input int ctl, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_b             = rst;
        ex_mem_read_en    = f[5];
        ex_complex        = f[4];
        ex_branch_taken   = f[3];
        ex_halted         = f[2];
        mem_cache_miss    = f[1];
        mem_cache_ready   = f[0];
        ex_write_register = wr;
        id_src1           = s1;
        id_uses_src1      = u1;
        id_src2           = s2;
        id_uses_src2      = u2;
        e.name = name;
        e.ctl  = ctl;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic idle(input string name, input int ctl, input int cnt);
        step(name, 1'b1, 6'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, ctl, cnt);
    endtask

    task automatic lu(input string name, input int ctl, input int cnt);
        step(name, 1'b1, F_RD, 5'd5, 5'd5, 1'b1, 5'd9, 1'b1, ctl, cnt);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb.pop_front();
            act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, halted};
            if (e.ctl >= 0) begin
                n_cmp++;
                if (act != e.ctl[7:0]) begin
                    n_bad++;
                    $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl[7:0]);
                end
            end
            if (e.cnt >= 0) begin
                n_cmp++;
                if (stall_cycles != e.cnt[3:0]) begin
                    n_bad++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        rst_b = 1'b0;
        {ex_mem_read_en, ex_complex, ex_branch_taken, ex_halted, mem_cache_miss, mem_cache_ready} = 6'b0;
        {id_src1, id_src2, ex_write_register, id_uses_src1, id_uses_src2} = '0;

        step("rst0", 1'b0, 6'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, -1, -1);
        step("rst1", 1'b0, 6'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_RST, 0);
        idle("idle0", C_DEF, 0);

        lu("lu_src1", C_LU, 0);
        idle("lu_after", C_DEF, 1);
        step("lu_r0", 1'b1, F_RD, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, C_DEF, 1);
        step("lu_src2", 1'b1, F_RD, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, C_LU, 1);
        step("lu_unused", 1'b1, F_RD, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, C_DEF, 2);
        step("lu_noload", 1'b1, 6'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, C_DEF, 2);

        step("br_lu", 1'b1, F_RD | F_BR, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, C_BR, 2);
        idle("br_after", C_DEF, 2);

        step("cx0", 1'b1, F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_CX, 2);
        step("cx1", 1'b1, F_CX | F_BR, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_CX, 3);
        step("cx2_miss", 1'b1, F_CX | F_MS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_CX, 4);
        step("cx_rel", 1'b1, F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_DEF, 5);
        idle("cx_after", C_DEF, 5);

        step("miss_t0", 1'b1, F_MS | F_RY, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_ALL0, 5);
        idle("miss_t1", C_ALL0, 6);
        idle("miss_t2", C_ALL0, 7);
        idle("miss_t3", C_ALL0, 8);
        idle("miss_t4", C_ALL0, 9);
        step("miss_t5", 1'b1, F_RY, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_DEF, 10);
        idle("miss_after", C_DEF, 10);

        step("rst_mid", 1'b0, F_MS, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_RST, 10);
        idle("rst_clear", C_DEF, 0);

        step("pri_mc", 1'b1, F_MS | F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_ALL0, 0);
        step("pri_wait", 1'b1, F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_ALL0, 1);
        step("pri_ready", 1'b1, F_CX | F_RY, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_DEF, 2);
        step("pri_cx0", 1'b1, F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_CX, 2);
        step("pri_cx1", 1'b1, F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_CX, 3);
        step("pri_cx2", 1'b1, F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_CX, 4);
        step("pri_rel", 1'b1, F_CX, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_DEF, 5);
        idle("pri_after", C_DEF, 5);

        step("halt_in", 1'b1, F_HT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_ALL0, 5);
        idle("halt_1", C_HALT, 5);
        step("halt_2", 1'b1, F_MS | F_RY, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_HALT, 5);
        step("halt_3", 1'b1, F_CX | F_BR, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_HALT, 5);
        lu("halt_4", C_HALT, 5);
        step("halt_rst", 1'b0, 6'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, -1, 5);
        idle("halt_clear", C_DEF, 0);

        for (int i = 0; i < 20; i++) begin
            lu($sformatf("sat_%0d", i), C_LU, (i > 15) ? 15 : i);
        end
        idle("sat_end", C_DEF, 15);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
